ring_freq_meter: RTL and testbench
==================================

// Module: ring_freq_meter
// PURPOSE
//  Measures an on-chip ring-oscillator output (or any free-running async toggle) by
//  counting its rising edges over a fixed window of clk cycles. The measuring end of the
//  ring-oscillator path: the oscillator drives a signal, and this block reads it back.
//  Publishes one count per window plus a valid strobe. Top bits are mirrored to LEDs.
// PARAMETERS
//  WINDOW_LOG2  16  window length = 2**WINDOW_LOG2 clk cycles
//  COUNT_W      16  width of edge counter / result
//  SYNC_STAGES  2   flip-flop stages in osc_in synchronizer (min 2)
// PORTS
//  clk          in   1        single system clock; all logic on posedge
//  rst_n        in   1        asynchronous, active-low reset
//  osc_in       in   1        async oscillator signal, unrelated to clk
//  enable       in   1        level; 1 = run back-to-back windows
//  count        out  COUNT_W  edge count of last completed window
//  count_valid  out  1        one-cycle pulse when count updates
//  overflow     out  1        last completed window saturated the edge counter
//  led          out  3        count[COUNT_W-1 -: 3] of last completed window
// BEHAVIOUR
//  - Reset: count=0, count_valid=0, overflow=0, led=0, FSM=IDLE, sync chain cleared.
//  - osc_in passes SYNC_STAGES flops, then rising-edge detect (sync_q & ~prev_q).
//    Detected rate is limited to clk/2; faster inputs alias. This is a documented limit.
//  - FSM: IDLE -> ARM -> MEASURE -> LATCH -> ARM (or IDLE).
//    IDLE: window_cnt=0 and edge_cnt=0. Moves to ARM when enable=1.
//    ARM: one cycle to clear window_cnt and edge_cnt. Edges in this cycle are not counted.
//    MEASURE: edge_cnt increments on each detected edge. It saturates at 2**COUNT_W-1
//      and sets an internal sat flag. window_cnt increments every cycle. The FSM leaves
//      after exactly 2**WINDOW_LOG2 MEASURE cycles (window_cnt wraps to 0).
//    LATCH: count<=edge_cnt, overflow<=sat, led updates, count_valid=1 for this cycle.
//      Goes to ARM if enable=1, else to IDLE.
//  - Result latency: count_valid asserts on the first cycle after the last MEASURE cycle.
//    Window period = 2**WINDOW_LOG2 + 2 cycles (ARM + LATCH) when back-to-back.
//  - An edge detected in the last MEASURE cycle is counted.
//  - If enable drops during ARM or MEASURE: go to IDLE next cycle, discard the partial
//    window, no count_valid. count, overflow and led hold their previous values.
//  - If enable drops during LATCH: the result is still published; next state is IDLE.
//  - rst_n asserted mid-window: everything returns to reset values at once, with no pulse.
//  - window_cnt is WINDOW_LOG2+1 bits wide. edge_cnt is COUNT_W bits, unsigned.
// STRUCTURE
//  - Shared header common/freq_meter_defs.vh holds:
//    FSM state localparams (IDLE=2'd0, ARM=2'd1, MEASURE=2'd2, LATCH=2'd3)
//    LED_BITS=3
//  - Sub-module sync_edge_det (common/sync_edge_det.v): SYNC_STAGES synchronizer plus
//    rising-edge detector. Inputs clk, rst_n, d. Output rise (one clk cycle).
//  - The top level instantiates the ring oscillator and feeds its output to osc_in.
// TESTING (bench: WINDOW_LOG2=6, COUNT_W=8, clk period 10ns)
//  1 Reset hold, then release with enable=0, osc toggling -> 20 cycles later:
//    count=0, count_valid never asserted.
//  2 enable=1, osc_in period 80ns (8 clk) phase-aligned -> each count_valid: count=8,
//    overflow=0. Pulses spaced exactly 66 cycles apart.
//  3 osc_in async period 37ns -> count in {17,18} every window; led=count[7:5].
//  4 COUNT_W=4 build, osc period 20ns (32 edges) -> count=15, overflow=1.
//    Next window at period 80ns -> count=8, overflow=0.
//  5 Drop enable 30 cycles into MEASURE -> no count_valid; count holds prior value.
//    Re-enable -> the first full window reports the correct count.
//  6 Assert rst_n low mid-MEASURE -> count/overflow/led=0 asynchronously, no pulse.
//    After release, the first valid arrives 66 cycles after enable is seen.

Source files
------------

// File: rtl/ring_freq_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ring_freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        LATCH   = 2'd3
    } meter_state_t;

    localparam int LED_BITS = 3;

endpackage

// File: rtl/ring_freq_meter_sync_edge_det.sv
// Purpose: synchronizes an async toggle into clk and flags its rising edges.
// Latency: rise asserts SYNC_STAGES cycles after the edge is first sampled.
// Backpressure: none; free-running, rise is a single-cycle pulse.
module ring_freq_meter_sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ring_freq_meter.sv
// Purpose: counts osc_in rising edges over 2**WINDOW_LOG2 clk cycles and publishes the count.
// Latency: count_valid pulses the cycle after the last MEASURE cycle; period 2**WINDOW_LOG2+2.
// Backpressure: none; results are fire-and-forget, enable low aborts the open window.
module ring_freq_meter
    import ring_freq_meter_pkg::*;
#(
    parameter int WINDOW_LOG2 = 16,
    parameter int COUNT_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               osc_in,
    input  logic               enable,
    output logic [COUNT_W-1:0] count,
    output logic               count_valid,
    output logic               overflow,
    output logic [2:0]         led
);

    localparam logic [COUNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [WINDOW_LOG2:0] WIN_LAST = {1'b0, {WINDOW_LOG2{1'b1}}};

    meter_state_t             state, state_nxt;
    logic [WINDOW_LOG2:0]     window_cnt;
    logic [COUNT_W-1:0]       edge_cnt, edge_nxt;
    logic                     sat, sat_nxt;
    logic                     rise;
    logic                     win_done;
    logic                     publish;

    ring_freq_meter_sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (osc_in),
        .rise  (rise)
    );

    // Saturating count including this cycle's edge, so the final MEASURE edge is published.
    always_comb begin
        edge_nxt = edge_cnt;
        if (rise && (edge_cnt != CNT_MAX))
            edge_nxt = edge_cnt + 1'b1;
        sat_nxt = sat | (edge_nxt == CNT_MAX);
    end

    assign win_done = (window_cnt == WIN_LAST);

    always_comb begin
        state_nxt = state;
        publish   = 1'b0;
        case (state)
            IDLE:    if (enable) state_nxt = ARM;
            ARM:     state_nxt = enable ? MEASURE : IDLE;
            MEASURE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (win_done) begin
                    state_nxt = LATCH;
                    publish   = 1'b1;
                end
            end
            LATCH:   state_nxt = enable ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            window_cnt  <= '0;
            edge_cnt    <= '0;
            sat         <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            count_valid <= publish;
            // Counters run only while staying in MEASURE; every other path leaves them cleared.
            if (state == MEASURE && state_nxt == MEASURE) begin
                window_cnt <= window_cnt + 1'b1;
                edge_cnt   <= edge_nxt;
                sat        <= sat_nxt;
            end else begin
                window_cnt <= '0;
                edge_cnt   <= '0;
                sat        <= 1'b0;
            end
            if (publish) begin
                count    <= edge_nxt;
                overflow <= sat_nxt;
            end
        end
    end

    assign led = count[COUNT_W-1 -: LED_BITS];

endmodule

// File: tb/tb_ring_freq_meter.sv
// Scoreboard bench: two builds (COUNT_W=8 and 4, window 64) share osc/enable; expectations
// come from edge counts of an ideal square wave over a 640 ns window.
`timescale 1ns/100ps
module tb_ring_freq_meter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       osc = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] count8;
    logic       cv8, ov8;
    logic [2:0] led8;
    logic [3:0] count4;
    logic       cv4, ov4;
    logic [2:0] led4;

    ring_freq_meter #(.WINDOW_LOG2(6), .COUNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .osc_in(osc), .enable(enable),
        .count(count8), .count_valid(cv8), .overflow(ov8), .led(led8)
    );

    ring_freq_meter #(.WINDOW_LOG2(6), .COUNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .osc_in(osc), .enable(enable),
        .count(count4), .count_valid(cv4), .overflow(ov4), .led(led4)
    );

    typedef struct {
        int lo;
        int hi;
        bit ovf_lo;
        bit ovf_hi;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   vc8[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   nv8 = 0;
    int   nv4 = 0;
    real  half_ns = 40.0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator transitions sit at x.3 ns so integral periods never race the clock edge.
    initial begin
        #1.3;
        forever begin
            #(half_ns) osc = ~osc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input int lo, input int hi, input int maxv);
        exp_t e;
        e.lo     = (lo > maxv) ? maxv : lo;
        e.hi     = (hi > maxv) ? maxv : hi;
        e.ovf_lo = (lo >= maxv);
        e.ovf_hi = (hi >= maxv);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic check_out(input string tag, input int cnt, input int ov, input int led,
                             input int sh, input exp_t e);
        chk_rng({tag, "_count"}, cnt, e.lo, e.hi);
        chk_rng({tag, "_overflow"}, ov, int'(e.ovf_lo), int'(e.ovf_hi));
        checks++;
        if (led != ((e.lo >> sh) & 7) && led != ((e.hi >> sh) & 7)) begin
            failures++;
            $display("FAIL %s_led: got %0d expected %0d or %0d", tag, led,
                     (e.lo >> sh) & 7, (e.hi >> sh) & 7);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (cv8) begin
            nv8++;
            vc8.push_back(cyc);
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid8: got count_valid=1 expected 0 (cyc=%0d)", cyc);
            end else begin
                e = q8.pop_front();
                check_out("w8", int'(count8), int'(ov8), int'(led8), 5, e);
            end
        end
        if (cv4) begin
            nv4++;
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid4: got count_valid=1 expected 0 (cyc=%0d)", cyc);
            end else begin
                e = q4.pop_front();
                check_out("w4", int'(count4), int'(ov4), int'(led4), 1, e);
            end
        end
    end

    // Run n back-to-back windows at oscillator half-period half10 (units of 0.1 ns).
    task automatic run_windows(input int half10, input int n);
        int p10, lo, hi, base, t_en, waited;
        half_ns = half10 / 10.0;
        repeat (45) @(negedge clk);
        p10 = 2 * half10;
        lo  = 6400 / p10;
        hi  = (6400 + p10 - 1) / p10;
        for (int k = 0; k < n; k++) begin
            q8.push_back(mk(lo, hi, 255));
            q4.push_back(mk(lo, hi, 15));
        end
        vc8.delete();
        base = nv8;
        @(negedge clk);
        enable = 1'b1;
        t_en = cyc;
        waited = 0;
        while (nv8 < base + n && waited < n * 66 + 40) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        enable = 1'b0;
        checks++;
        if (nv8 < base + n) begin
            failures++;
            $display("FAIL window_timeout: got %0d valids expected %0d", nv8 - base, n);
            q8.delete();
            q4.delete();
        end
        for (int k = 0; k < n; k++) begin
            if (k < vc8.size())
                chk("valid_spacing", vc8[k] - t_en, 66 * (k + 1));
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int base;
        repeat (5) @(negedge clk);
        chk("reset_count8", int'(count8), 0);
        chk("reset_valid8", int'(cv8), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_count8", int'(count8), 0);
        chk("idle_overflow8", int'(ov8), 0);
        chk("idle_led8", int'(led8), 0);
        chk("idle_count4", int'(count4), 0);
        chk("idle_nvalid", nv8 + nv4, 0);

        run_windows(400, 3);   // 80 ns: exactly 8 edges
        run_windows(100, 2);   // 20 ns: 32 edges, saturates the 4-bit build
        run_windows(400, 2);
        run_windows(185, 3);   // 37 ns: 17 or 18 edges
        repeat (6) run_windows($urandom_range(105, 1500), 2);
        run_windows(400, 2);

        // Abort 30 cycles into MEASURE: no pulse, previous result held.
        base = nv8;
        @(negedge clk);
        enable = 1'b1;
        repeat (32) @(negedge clk);
        enable = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_no_valid", nv8 - base, 0);
        chk("abort_hold_count8", int'(count8), 8);
        chk("abort_hold_count4", int'(count4), 8);
        chk("abort_hold_led4", int'(led4), 4);
        chk("abort_hold_overflow4", int'(ov4), 0);
        run_windows(400, 1);

        // Asynchronous reset in the middle of MEASURE.
        base = nv8;
        @(negedge clk);
        enable = 1'b1;
        repeat (40) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count8", int'(count8), 0);
        chk("arst_led4", int'(led4), 0);
        chk("arst_count4", int'(count4), 0);
        chk("arst_overflow8", int'(ov8), 0);
        chk("arst_valid8", int'(cv8), 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_no_valid", nv8 - base, 0);
        run_windows(400, 1);

        chk("leftover_q8", q8.size(), 0);
        chk("leftover_q4", q4.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
